// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU host command engine: FSM state
// encoding, packet framing constants, opcodes and the packet length helper.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_RESP    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int         HDR_BYTES     = 4;
    localparam logic [7:0] RESERVED_BYTE = 8'h00;

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD32 = 8'hA8;
    localparam logic [7:0] OP_MUL32 = 8'hAD;
    localparam logic [7:0] OP_DIV32 = 8'hAB;

    // Total packet length in bytes (header plus payload), carried in 16 bits.
    function automatic logic [15:0] packet_len(input logic [15:0] count,
                                               input logic [15:0] op_bytes);
        logic [15:0] payload;
        payload = count * op_bytes;
        return 16'(HDR_BYTES) + payload;
    endfunction

endpackage

// File: rtl/uart_alu_host_ser.sv
// Transmit byte selector: maps a packet byte index onto the header fields or
// the captured operand bytes. The index only advances on a handshake, so the
// presented byte is held stable while the sink stalls.
module uart_alu_host_ser
    import uart_alu_pkg::*;
#(
    parameter int OPERAND_WIDTH_P = 32,
    parameter int MAX_OPERANDS_P  = 4
) (
    input  logic                                  active,
    input  logic [7:0]                            opcode,
    input  logic [15:0]                           len,
    input  logic [MAX_OPERANDS_P*OPERAND_WIDTH_P-1:0] operands,
    input  logic [15:0]                           byte_idx,
    input  logic                                  tx_tready,
    output logic [7:0]                            tx_tdata,
    output logic                                  tx_tvalid,
    output logic                                  fire,
    output logic                                  hdr_last,
    output logic                                  last
);

    localparam int PAYLOAD_BYTES = MAX_OPERANDS_P * OPERAND_WIDTH_P / 8;

    logic [15:0] pay_idx;

    assign pay_idx   = byte_idx - 16'(HDR_BYTES);
    assign tx_tvalid = active;
    assign fire      = active && tx_tready;
    assign hdr_last  = (byte_idx == 16'(HDR_BYTES - 1));
    assign last      = (byte_idx == len - 16'd1);

    // Select the header field or operand byte addressed by byte_idx.
    always_comb begin
        tx_tdata = RESERVED_BYTE;
        case (byte_idx)
            16'd0:   tx_tdata = opcode;
            16'd1:   tx_tdata = RESERVED_BYTE;
            16'd2:   tx_tdata = len[7:0];
            16'd3:   tx_tdata = len[15:8];
            default: begin
                for (int b = 0; b < PAYLOAD_BYTES; b++) begin
                    if (pay_idx == 16'(b)) begin
                        tx_tdata = operands[b*8 +: 8];
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/uart_alu_host.sv
// Host-side UART ALU command engine: frames one command onto the tx byte
// stream, then assembles a fixed-length little-endian response from rx.
// Optional feature macro: UART_ALU_HOST_TIMEOUT_EN enables the inter-byte
// response timeout; without it RESP waits indefinitely.
module uart_alu_host
    import uart_alu_pkg::*;
#(
    parameter int OPERAND_WIDTH_P  = 32,
    parameter int MAX_OPERANDS_P   = 4,
    parameter int MAX_RESP_BYTES_P = 4,
    parameter int TIMEOUT_CYCLES_P = 100000
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cmd_valid_i,
    output logic                                      cmd_ready_o,
    input  logic [7:0]                                cmd_opcode_i,
    input  logic [$clog2(MAX_OPERANDS_P+1)-1:0]       cmd_count_i,
    input  logic [MAX_OPERANDS_P*OPERAND_WIDTH_P-1:0] cmd_operands_i,
    input  logic [$clog2(MAX_RESP_BYTES_P+1)-1:0]     cmd_resp_bytes_i,
    output logic [7:0]                                tx_tdata_o,
    output logic                                      tx_tvalid_o,
    input  logic                                      tx_tready_i,
    input  logic [7:0]                                rx_tdata_i,
    input  logic                                      rx_tvalid_i,
    output logic                                      rx_tready_o,
    output logic                                      rsp_valid_o,
    input  logic                                      rsp_ready_i,
    output logic [8*MAX_RESP_BYTES_P-1:0]             rsp_data_o,
    output logic                                      rsp_timeout_o,
    output logic                                      busy_o
);

    localparam int CNT_W  = $clog2(MAX_OPERANDS_P + 1);
    localparam int RSP_W  = $clog2(MAX_RESP_BYTES_P + 1);
    localparam int OPND_W = MAX_OPERANDS_P * OPERAND_WIDTH_P;

    state_e                         state_q;
    state_e                         after_tx;
    logic [7:0]                     opcode_q;
    logic [CNT_W-1:0]               count_q;
    logic [OPND_W-1:0]              operands_q;
    logic [RSP_W-1:0]               resp_len_q;
    logic [15:0]                    len_q;
    logic [15:0]                    tx_idx_q;
    logic [RSP_W-1:0]               rx_idx_q;
    logic [8*MAX_RESP_BYTES_P-1:0]  rsp_data_q;
    logic [CNT_W-1:0]               count_sat;
    logic [RSP_W-1:0]               resp_sat;
    logic                           accept;
    logic                           tx_fire;
    logic                           tx_hdr_last;
    logic                           tx_last;
    logic                           rx_fire;
    logic                           rx_last;
    logic                           tmo_hit;

    assign accept      = (state_q == ST_IDLE) && cmd_valid_i;
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rx_tready_o = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign rsp_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_data_o  = rsp_data_q;
    assign rx_fire     = rx_tvalid_i && rx_tready_o;
    assign rx_last     = (rx_idx_q + RSP_W'(1)) == resp_len_q;
    assign after_tx    = (resp_len_q == '0) ? ST_DONE : ST_RESP;

    assign count_sat = (cmd_count_i > CNT_W'(MAX_OPERANDS_P))
                       ? CNT_W'(MAX_OPERANDS_P) : cmd_count_i;
    assign resp_sat  = (cmd_resp_bytes_i > RSP_W'(MAX_RESP_BYTES_P))
                       ? RSP_W'(MAX_RESP_BYTES_P) : cmd_resp_bytes_i;

    uart_alu_host_ser #(
        .OPERAND_WIDTH_P (OPERAND_WIDTH_P),
        .MAX_OPERANDS_P  (MAX_OPERANDS_P)
    ) u_ser (
        .active    ((state_q == ST_HDR) || (state_q == ST_PAYLOAD)),
        .opcode    (opcode_q),
        .len       (len_q),
        .operands  (operands_q),
        .byte_idx  (tx_idx_q),
        .tx_tready (tx_tready_i),
        .tx_tdata  (tx_tdata_o),
        .tx_tvalid (tx_tvalid_o),
        .fire      (tx_fire),
        .hdr_last  (tx_hdr_last),
        .last      (tx_last)
    );

`ifdef UART_ALU_HOST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES_P + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;

    assign tmo_hit       = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES_P - 1)) && !rx_fire;
    assign rsp_timeout_o = timeout_q;

    // Idle-cycle counter: held at zero outside RESP and on every rx byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if ((state_q != ST_RESP) || rx_fire) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    // Timeout flag: cleared at accept, set when RESP is abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (accept) begin
            timeout_q <= 1'b0;
        end else if ((state_q == ST_RESP) && tmo_hit) begin
            timeout_q <= 1'b1;
        end
    end
`else
    assign tmo_hit       = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    // Command engine FSM and the tx/rx byte indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tx_idx_q <= '0;
            rx_idx_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        state_q  <= ST_HDR;
                        tx_idx_q <= '0;
                        rx_idx_q <= '0;
                    end
                end
                ST_HDR: begin
                    if (tx_fire) begin
                        tx_idx_q <= tx_idx_q + 16'd1;
                        if (tx_hdr_last) begin
                            state_q <= (count_q == '0) ? after_tx : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (tx_fire) begin
                        tx_idx_q <= tx_idx_q + 16'd1;
                        if (tx_last) begin
                            state_q <= after_tx;
                        end
                    end
                end
                ST_RESP: begin
                    if (rx_fire) begin
                        rx_idx_q <= rx_idx_q + RSP_W'(1);
                        if (rx_last) begin
                            state_q <= ST_DONE;
                        end
                    end else if (tmo_hit) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Command field capture at accept; held for the whole transaction.
    always_ff @(posedge clk) begin
        if (accept) begin
            opcode_q   <= cmd_opcode_i;
            operands_q <= cmd_operands_i;
            count_q    <= count_sat;
            resp_len_q <= resp_sat;
            len_q      <= packet_len(16'(count_sat), 16'(OPERAND_WIDTH_P / 8));
        end
    end

    // Response assembly: cleared at accept, byte k lands in lane k.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q <= '0;
        end else if (accept) begin
            rsp_data_q <= '0;
        end else if ((state_q == ST_RESP) && rx_fire) begin
            for (int k = 0; k < MAX_RESP_BYTES_P; k++) begin
                if (rx_idx_q == RSP_W'(k)) begin
                    rsp_data_q[k*8 +: 8] <= rx_tdata_i;
                end
            end
        end
    end

endmodule
